// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the host command parser: ASCII codes, FSM states and
// digit-count sizing.
package uart_cmd_pkg;

  localparam logic [7:0] CH_W  = 8'h57;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEP1    = 3'd1,
    ADDR    = 3'd2,
    SEP2    = 3'd3,
    DATA    = 3'd4,
    EOL     = 3'd5,
    DISCARD = 3'd6
  } state_t;

  // Digit counter holds the index of the digit being received.
  localparam int               DCNT_W    = 2;
  localparam logic [DCNT_W-1:0] ADDR_LAST = 2'd1;
  localparam logic [DCNT_W-1:0] DATA_LAST = 2'd3;

  function automatic logic is_eol(input logic [7:0] b);
    return (b == CH_CR) || (b == CH_LF);
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte input and register-strobe output bundle of the command parser.
// rx_data is valid only in cycles with rx_data_ready=1; there is no back-pressure.
interface uart_cmd_parser_if #(
  parameter int ERR_CNT_W = 8
);
  logic                   rx_data_ready;
  logic [7:0]             rx_data;
  logic                   reg_wr;
  logic                   reg_rd;
  logic [7:0]             reg_addr;
  logic [15:0]            reg_wdata;
  logic                   cmd_err;
  logic [ERR_CNT_W-1:0]   err_count;
  logic                   busy;
  uart_cmd_pkg::state_t   dbg_state;

  modport slave (
    input  rx_data_ready, rx_data,
    output reg_wr, reg_rd, reg_addr, reg_wdata, cmd_err, err_count, busy, dbg_state
  );

  modport master (
    output rx_data_ready, rx_data,
    input  reg_wr, reg_rd, reg_addr, reg_wdata, cmd_err, err_count, busy, dbg_state
  );
endinterface

// File: rtl/ascii_hex_decode.sv
// Combinational ASCII hex digit decoder (0-9, A-F, a-f).
module ascii_hex_decode (
  input  logic [7:0] byte_i,
  output logic [3:0] nibble_o,
  output logic       valid_o
);
  // Letters A-F / a-f have low nibble 1..6, so adding 9 yields 10..15.
  always_comb begin
    nibble_o = 4'h0;
    valid_o  = 1'b0;
    if (byte_i >= 8'h30 && byte_i <= 8'h39) begin
      nibble_o = byte_i[3:0];
      valid_o  = 1'b1;
    end else if ((byte_i >= 8'h41 && byte_i <= 8'h46) ||
                 (byte_i >= 8'h61 && byte_i <= 8'h66)) begin
      nibble_o = byte_i[3:0] + 4'd9;
      valid_o  = 1'b1;
    end
  end
endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII-hex command line parser: "W aa dddd" / "R aa" lines terminated by CR or LF
// become one-cycle register strobes; malformed lines raise cmd_err and are dropped.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int ERR_CNT_W      = 8
) (
  input logic              CLK_10MHZ,
  input logic              RST,
  uart_cmd_parser_if.slave bus
);

  localparam int               TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t                state_q;
  logic                  is_wr_q;
  logic [DCNT_W-1:0]     dcnt_q;
  logic [7:0]            addr_sh_q;
  logic [15:0]           data_sh_q;
  logic [TMO_W-1:0]      tmo_q;
  logic                  reg_wr_q;
  logic                  reg_rd_q;
  logic                  cmd_err_q;
  logic [7:0]            reg_addr_q;
  logic [15:0]           reg_wdata_q;
  logic [ERR_CNT_W-1:0]  err_cnt_q;
  logic [ERR_CNT_W-1:0]  err_cnt_d;
  state_t                err_state_d;
  logic [7:0]            rx_byte;
  logic [3:0]            nib;
  logic                  hex_v;

  assign rx_byte = bus.rx_data;

  ascii_hex_decode u_hex (
    .byte_i   (rx_byte),
    .nibble_o (nib),
    .valid_o  (hex_v)
  );

  // A bad byte that is itself a terminator ends the line; anything else waits for one.
  assign err_cnt_d   = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;
  assign err_state_d = is_eol(rx_byte) ? IDLE : DISCARD;

  always_ff @(posedge CLK_10MHZ) begin
    if (RST) begin
      state_q     <= IDLE;
      is_wr_q     <= 1'b0;
      dcnt_q      <= '0;
      addr_sh_q   <= '0;
      data_sh_q   <= '0;
      tmo_q       <= '0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      cmd_err_q   <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      reg_wr_q  <= 1'b0;
      reg_rd_q  <= 1'b0;
      cmd_err_q <= 1'b0;
      if (bus.rx_data_ready) begin
        tmo_q <= '0;
        case (state_q)
          IDLE: begin
            if (rx_byte == CH_W || rx_byte == CH_R) begin
              is_wr_q <= (rx_byte == CH_W);
              state_q <= SEP1;
            end else if (!(is_eol(rx_byte) || rx_byte == CH_SP)) begin
              cmd_err_q <= 1'b1;
              err_cnt_q <= err_cnt_d;
              state_q   <= DISCARD;
            end
          end
          SEP1: begin
            if (rx_byte == CH_SP) begin
              dcnt_q  <= '0;
              state_q <= ADDR;
            end else begin
              cmd_err_q <= 1'b1;
              err_cnt_q <= err_cnt_d;
              state_q   <= err_state_d;
            end
          end
          ADDR: begin
            if (hex_v) begin
              addr_sh_q <= {addr_sh_q[3:0], nib};
              dcnt_q    <= dcnt_q + 1'b1;
              if (dcnt_q == ADDR_LAST) state_q <= is_wr_q ? SEP2 : EOL;
            end else begin
              cmd_err_q <= 1'b1;
              err_cnt_q <= err_cnt_d;
              state_q   <= err_state_d;
            end
          end
          SEP2: begin
            if (rx_byte == CH_SP) begin
              dcnt_q  <= '0;
              state_q <= DATA;
            end else begin
              cmd_err_q <= 1'b1;
              err_cnt_q <= err_cnt_d;
              state_q   <= err_state_d;
            end
          end
          DATA: begin
            if (hex_v) begin
              data_sh_q <= {data_sh_q[11:0], nib};
              dcnt_q    <= dcnt_q + 1'b1;
              if (dcnt_q == DATA_LAST) state_q <= EOL;
            end else begin
              cmd_err_q <= 1'b1;
              err_cnt_q <= err_cnt_d;
              state_q   <= err_state_d;
            end
          end
          EOL: begin
            if (is_eol(rx_byte)) begin
              reg_addr_q <= addr_sh_q;
              if (is_wr_q) begin
                reg_wdata_q <= data_sh_q;
                reg_wr_q    <= 1'b1;
              end else begin
                reg_rd_q <= 1'b1;
              end
              state_q <= IDLE;
            end else begin
              cmd_err_q <= 1'b1;
              err_cnt_q <= err_cnt_d;
              state_q   <= DISCARD;
            end
          end
          DISCARD: if (is_eol(rx_byte)) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end else if (state_q != IDLE) begin
        // Stalled mid-line: an expired line is reported, a discarded one is not.
        if (tmo_q == TMO_LAST) begin
          tmo_q   <= '0;
          state_q <= IDLE;
          if (state_q != DISCARD) begin
            cmd_err_q <= 1'b1;
            err_cnt_q <= err_cnt_d;
          end
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end
    end
  end

  assign bus.reg_wr    = reg_wr_q;
  assign bus.reg_rd    = reg_rd_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.cmd_err   = cmd_err_q;
  assign bus.err_count = err_cnt_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.dbg_state = state_q;

endmodule
